signed_seg7_display: RTL and testbench
======================================

Name: signed_seg7_display

Overview:
- Display stage directly downstream of the sign changer: takes its 8-bit two's-complement result and overflow flag, and shows the value as signed decimal on a 4-digit multiplexed common-anode 7-segment display.
- Internally:
  - captures the value through a valid/ready handshake;
  - converts the magnitude to BCD with a sequential shift-add-3 (double dabble) engine;
  - time-multiplexes the digits at a parameterised refresh rate.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays enabled (legal ≥2)

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  value/ovfl are valid this cycle
in_ready  out  1  block can accept a new value (high only in IDLE)
value  in  8  two's-complement number to display
ovfl  in  1  overflow flag accompanying value
seg  out  7  segments {g,f,e,d,c,b,a}, active-low, registered
dp  out  1  decimal point, active-low; constant 1 (off)
an  out  4  digit enables, active-low, one-hot-low, registered; an[0] = rightmost
busy  out  1  high while in CONVERT or UPDATE

Behaviour:
- Reset (async assert, sync release):
  - FSM = IDLE; in_ready = 1; busy = 0.
  - an = 4'b1111; seg = 7'h7F; dp = 1.
  - Displayed registers = value 0, non-negative, no overflow.
  - Scan divider and digit index = 0.
- FSM states:
  - IDLE → CONVERT on in_valid & in_ready.
    - Captures neg = value[7], ovf = ovfl.
    - Captures mag = value[7] ? (~value + 1) : value, 8-bit unsigned. −128 → mag = 128, with no special case.
  - CONVERT: exactly 8 cycles. Each cycle:
    - add 3 to every BCD nibble ≥ 5;
    - then shift {bcd[11:0], mag} left by one.
  - UPDATE: 1 cycle. Copies bcd/neg/ovf into the display registers, then → IDLE.
- Latency: accept at edge N; display registers change at edge N+9; in_ready low for edges N+1..N+9. in_valid during that window is ignored, with no queuing.
- Display holds the previous value until UPDATE, so there is no flicker mid-conversion.
- Digit content (index 0 = ones … 3 = sign):
  - ones: always a digit.
  - tens: blank if hundreds = 0 and tens = 0.
  - hundreds: blank if 0.
  - digit 3: dash if neg, else blank.
  - If ovf: all four digits show a dash ("----"), regardless of value.
- Segment codes (active-low, gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111, blank = 1111111
- Scan:
  - Divider counts 0..REFRESH_DIV−1; on wrap, digit index increments mod 4.
  - an/seg are registered from the index and content, so they lag the index by one cycle and change together.
  - The first edge after reset release loads an = 4'b1110 with the ones digit.
  - Scanning runs in all FSM states.
- Simultaneous events: the handshake at the same edge as a digit wrap causes no interaction. Reset mid-CONVERT abandons the conversion, and the display reverts to 0.
- Width rule: mag ≤ 128, so hundreds ≤ 1. The BCD register is still 12 bits. No arithmetic overflow is possible internally.

Decomposition:
- Shared package holds:
  - the segment code constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - the FSM state encoding (IDLE, CONVERT, UPDATE, 2 bits);
  - DIGITS = 4.
- One sub-module, seg7_digit_decode: combinational 4-bit BCD + blank/dash selects → 7-bit active-low segments.
- FSM, double-dabble engine and scan counter stay in the top level.

Test Plan (REFRESH_DIV = 4):
- Reset then release → an = 1111 / seg = 7F during reset; after release, the ones digit shows 1000000 ("0") and digits 1–3 are blank.
- Send value = 8'd123, ovfl = 0 → in_ready low for 9 edges. After UPDATE, the scan shows ones = 0110000, tens = 0100100, hundreds = 1111001, sign = blank.
- Send value = 8'hF9 (−7) → ones = 1111000 ("7"), tens/hundreds blank, sign = 0111111.
- Send value = 8'h80 (−128) → digits "-128": sign = dash, hundreds = 1, tens = 2, ones = 8.
- Send value = 8'h05 with ovfl = 1 → all four digits = 0111111.
- Pulse in_valid with 8'd42 mid-CONVERT → input ignored; then assert rst_n = 0 during CONVERT → outputs immediately reset, and the FSM resumes in IDLE showing "0".

Source files
------------

// File: rtl/signed_seg7_display_pkg.sv
// Shared constants for the signed 7-segment display: segment codes, FSM encoding, digit count.
package signed_seg7_display_pkg;

  localparam int unsigned DIGITS = 4;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_e;

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD digit to active-low 7-segment decoder with dash/blank overrides.
module seg7_digit_decode
  import signed_seg7_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       dash,
  output logic [6:0] seg
);

  // Dash wins over blank so overflow always shows "----"
  always_comb begin
    seg = SEG_BLANK;
    if (dash) begin
      seg = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/signed_seg7_display.sv
// Signed 8-bit value to 4-digit multiplexed common-anode display:
// handshake capture, sequential double-dabble conversion, digit scan.
module signed_seg7_display
  import signed_seg7_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] value,
  input  logic       ovfl,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       busy
);

  localparam int unsigned DivW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic        neg_q, ovf_q;
  logic [11:0] disp_bcd_q;
  logic        disp_neg_q, disp_ovf_q;
  logic [DivW-1:0] div_q;
  logic [1:0]  idx_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]  seg_q;

  logic [11:0] bcd_adj;
  logic        unused_adj_msb;
  logic [3:0]  dig_bcd;
  logic        dig_blank, dig_dash;
  logic [6:0]  dig_seg;

  assign bcd_adj        = dd_adjust(bcd_q);
  // Hundreds never exceeds 1, so the adjusted top bit is shifted out unused
  assign unused_adj_msb = bcd_adj[11];

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == CONVERT) || (state_q == UPDATE);
  assign dp       = 1'b1;
  assign an       = an_q;
  assign seg      = seg_q;

  // Capture, convert over 8 shift cycles, then publish to the display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      disp_ovf_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            neg_q   <= value[7];
            ovf_q   <= ovfl;
            // -128 negates to 8'h80, which is the correct unsigned magnitude 128
            mag_q   <= value[7] ? (~value + 8'd1) : value;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= CONVERT;
          end
        end
        CONVERT: begin
          {bcd_q, mag_q} <= {bcd_adj[10:0], mag_q, 1'b0};
          cnt_q          <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_q <= UPDATE;
        end
        UPDATE: begin
          disp_bcd_q <= bcd_q;
          disp_neg_q <= neg_q;
          disp_ovf_q <= ovf_q;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Refresh divider and digit index; runs independently of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      div_q <= div_q + DivW'(1);
    end
  end

  // Select content and blanking for the digit currently being scanned
  always_comb begin
    dig_bcd   = disp_bcd_q[3:0];
    dig_blank = 1'b0;
    dig_dash  = disp_ovf_q;
    case (idx_q)
      2'd0: dig_bcd = disp_bcd_q[3:0];
      2'd1: begin
        dig_bcd   = disp_bcd_q[7:4];
        dig_blank = (disp_bcd_q[11:8] == 4'd0) && (disp_bcd_q[7:4] == 4'd0);
      end
      2'd2: begin
        dig_bcd   = disp_bcd_q[11:8];
        dig_blank = (disp_bcd_q[11:8] == 4'd0);
      end
      default: begin
        dig_blank = !disp_neg_q;
        dig_dash  = disp_neg_q || disp_ovf_q;
      end
    endcase
  end

  seg7_digit_decode u_decode (
    .bcd   (dig_bcd),
    .blank (dig_blank),
    .dash  (dig_dash),
    .seg   (dig_seg)
  );

  // Register anode and segments together so they never disagree on a digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= ~(DIGITS'(1) << idx_q);
      seg_q <= dig_seg;
    end
  end

endmodule

// File: tb/tb_signed_seg7_display.sv
// Scoreboard bench: stimulus pushes expected 4-digit patterns, a monitor checks each new display.
module tb_signed_seg7_display;

  localparam int unsigned REFRESH_DIV = 4;

  localparam logic [6:0] T_DASH  = 7'b0111111;
  localparam logic [6:0] T_BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] value = 8'd0;
  logic       ovfl = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       busy;

  int n_tests = 0;
  int n_fail = 0;
  int scans_done = 0;
  bit rel_pulse = 1'b0;
  logic prev_busy = 1'b0;
  logic [27:0] exp_q[$];

  signed_seg7_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .value    (value),
    .ovfl     (ovfl),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Reference: signed decimal rendering, digit 0 in bits [6:0] ... sign in [27:21]
  function automatic logic [27:0] model(input logic [7:0] v, input logic o);
    int s, m, h, t, u;
    logic [6:0] d0, d1, d2, d3;
    s = $signed(v);
    m = (s < 0) ? -s : s;
    if (o) return {4{T_DASH}};
    h = m / 100;
    t = (m / 10) % 10;
    u = m % 10;
    d0 = seg_of(u);
    d1 = (h == 0 && t == 0) ? T_BLANK : seg_of(t);
    d2 = (h == 0) ? T_BLANK : seg_of(h);
    d3 = (s < 0) ? T_DASH : T_BLANK;
    return {d3, d2, d1, d0};
  endfunction

  // Monitor: on each display refresh, observe a full scan and compare with the scoreboard
  initial begin
    logic [27:0] exp;
    logic [6:0] got[4];
    bit seen[4];
    forever begin
      @(negedge clk);
      if (rst_n && ((prev_busy && !busy) || rel_pulse)) begin
        rel_pulse = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          for (int i = 0; i < 4; i++) seen[i] = 1'b0;
          repeat (4 * REFRESH_DIV + 3) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
              if (an == ~(4'b0001 << i)) begin
                got[i]  = seg;
                seen[i] = 1'b1;
              end
            end
          end
          for (int i = 0; i < 4; i++) begin
            if (!seen[i]) check($sformatf("digit%0d_not_scanned", i), 32'd0, 32'd1);
            else check($sformatf("digit%0d_seg", i), {25'd0, got[i]}, {25'd0, exp[7*i +: 7]});
          end
        end
        scans_done++;
      end
      prev_busy = busy;
    end
  end

  task automatic wait_scan(input int target);
    int t = 0;
    while (scans_done < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    check("scan_completed", {31'd0, scans_done >= target}, 32'd1);
  endtask

  task automatic send(input logic [7:0] v, input logic o, input bit poke);
    int lat = 0;
    int target;
    @(negedge clk);
    check("ready_before_send", {31'd0, in_ready}, 32'd1);
    value = v;
    ovfl = o;
    in_valid = 1'b1;
    exp_q.push_back(model(v, o));
    target = scans_done + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value = 8'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!in_ready && lat < 50) begin
      // A request raised mid-conversion must be dropped
      if (poke && lat == 3) begin
        in_valid = 1'b1;
        value = 8'd42;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("accept_to_ready_edges", lat, 32'd9);
    wait_scan(target);
  endtask

  task automatic reset_release_check();
    int target;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_an_after_reset", {28'd0, an}, 32'b1110);
    check("first_seg_after_reset", {25'd0, seg}, 32'b1000000);
    exp_q.push_back(model(8'd0, 1'b0));
    target = scans_done + 1;
    rel_pulse = 1'b1;
    wait_scan(target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_an", {28'd0, an}, 32'hF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    check("reset_dp", {31'd0, dp}, 32'd1);
    check("reset_ready", {31'd0, in_ready}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset_release_check();

    send(8'd123, 1'b0, 1'b0);
    send(8'hF9, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0);
    send(8'd42, 1'b0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      send(8'($urandom), ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1);
    end

    // Reset during a conversion: abandoned, display falls back to "0"
    @(negedge clk);
    value = 8'd99;
    ovfl = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b1;
    value = 8'd42;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_mid_convert", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_an", {28'd0, an}, 32'hF);
    check("midreset_seg", {25'd0, seg}, 32'h7F);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    reset_release_check();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
